// File: rtl/pl_skid_fd_if.sv
// Fetch->decode pipeline register bus: fetch-side beat, decode-side beat, flush controls
// and occupancy. The fetch/flush driver uses master; the pipeline register uses slave.
interface pl_skid_fd_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_THREADS   = 8
);
   localparam int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   logic                     flush;
   logic                     flush_tid_en;
   logic [BITS_THREADS-1:0]  flush_tid;

   logic                     valid_f;
   logic                     ready_f;
   logic [ADDRESS_WIDTH-1:0] pc_f;
   logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
   logic [DATA_WIDTH-1:0]    instr_f;
   logic [BITS_THREADS-1:0]  tid_f;

   logic                     valid_d;
   logic                     ready_d;
   logic [ADDRESS_WIDTH-1:0] pc_d;
   logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
   logic [DATA_WIDTH-1:0]    instr_d;
   logic [BITS_THREADS-1:0]  tid_d;
   logic [1:0]               occupancy;

   modport master (
      output flush, flush_tid_en, flush_tid,
      output valid_f, pc_f, pc_plus4_f, instr_f, tid_f, ready_d,
      input  ready_f, valid_d, pc_d, pc_plus4_d, instr_d, tid_d, occupancy
   );

   modport slave (
      input  flush, flush_tid_en, flush_tid,
      input  valid_f, pc_f, pc_plus4_f, instr_f, tid_f, ready_d,
      output ready_f, valid_d, pc_d, pc_plus4_d, instr_d, tid_d, occupancy
   );
endinterface

// File: rtl/pl_skid_fd.sv
// Fetch->decode pipeline register with a 2-entry skid buffer (main + skid), global flush
// and per-thread flush. All outputs come straight from registers.
module pl_skid_fd #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_THREADS   = 8,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013)
) (
   input  logic         clk,
   input  logic         rst,
   pl_skid_fd_if.slave  fd_if
);
   localparam int BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [ADDRESS_WIDTH-1:0] pc_plus4;
      logic [DATA_WIDTH-1:0]    instr;
      logic [BITS_THREADS-1:0]  tid;
   } entry_t;

   localparam entry_t ENTRY_RST = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, tid: '0};

   state_t state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d, in_entry;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   kill_in, push, pop, main_keep, skid_keep;

   assign in_entry = '{pc: fd_if.pc_f, pc_plus4: fd_if.pc_plus4_f,
                       instr: fd_if.instr_f, tid: fd_if.tid_f};

   assign kill_in   = fd_if.flush_tid_en && (fd_if.tid_f == fd_if.flush_tid);
   assign push      = fd_if.valid_f && (state_q != FULL) && !fd_if.flush && !kill_in;
   assign pop       = main_valid_q && fd_if.ready_d;
   // An entry survives into the next cycle only if it is neither consumed nor killed.
   assign main_keep = main_valid_q && !pop &&
                      !(fd_if.flush_tid_en && (main_q.tid == fd_if.flush_tid));
   assign skid_keep = skid_valid_q &&
                      !(fd_if.flush_tid_en && (skid_q.tid == fd_if.flush_tid));

   // Survivors are compacted oldest-first (main, skid), then the new beat is appended.
   // Push requires an empty skid, so at most two entries ever remain.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_keep;
      skid_valid_d = 1'b0;
      if (main_keep) begin
         if (skid_keep) begin
            skid_valid_d = 1'b1;
         end else if (push) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
      end else if (skid_keep) begin
         main_d       = skid_q;
         main_valid_d = 1'b1;
      end else if (push) begin
         main_d       = in_entry;
         main_valid_d = 1'b1;
      end
      if (fd_if.flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
      if (skid_valid_d)      state_d = FULL;
      else if (main_valid_d) state_d = ONE;
      else                   state_d = EMPTY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         main_q       <= ENTRY_RST;
         skid_q       <= ENTRY_RST;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign fd_if.ready_f    = (state_q != FULL);
   assign fd_if.valid_d    = main_valid_q;
   assign fd_if.pc_d       = main_q.pc;
   assign fd_if.pc_plus4_d = main_q.pc_plus4;
   assign fd_if.instr_d    = main_valid_q ? main_q.instr : NOP_INSTR;
   assign fd_if.tid_d      = main_q.tid;
   assign fd_if.occupancy  = state_q;

   a_skid_needs_main: assert property (@(posedge clk) disable iff (rst)
      skid_valid_q |-> main_valid_q);
endmodule

// File: tb/tb_pl_skid_fd.sv
// Directed-vector bench for pl_skid_fd with hand-computed expectations.
module tb_pl_skid_fd;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NT = 8;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pl_skid_fd_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_THREADS(NT)) bus ();

   pl_skid_fd #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_THREADS(NT)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .fd_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [2:0] tid);
      bus.valid_f    = v;
      bus.pc_f       = pc;
      bus.pc_plus4_f = pc + 32'd4;
      bus.instr_f    = instr;
      bus.tid_f      = tid;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic rf,
                            input logic [1:0] occ);
      chk({tag, ".valid_d"}, 32'(bus.valid_d), 32'(v));
      chk({tag, ".ready_f"}, 32'(bus.ready_f), 32'(rf));
      chk({tag, ".occ"}, 32'(bus.occupancy), 32'(occ));
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      bus.flush        = 1'b0;
      bus.flush_tid_en = 1'b0;
      bus.flush_tid    = 3'd0;
      bus.ready_d      = 1'b0;
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      cyc();
      cyc();
      chk_state("reset", 1'b0, 1'b1, 2'd0);
      chk("reset.instr_d", bus.instr_d, 32'h00000013);
      chk("reset.pc_d", bus.pc_d, 32'h0);
      chk("reset.tid_d", 32'(bus.tid_d), 32'd0);
      rst = 1'b0;
      cyc();

      // single beat, 1-cycle latency
      bus.ready_d = 1'b1;
      drv(1'b1, 32'h100, 32'h00500093, 3'd3);
      cyc();
      chk_state("single", 1'b1, 1'b1, 2'd1);
      chk("single.pc_d", bus.pc_d, 32'h100);
      chk("single.pc_plus4_d", bus.pc_plus4_d, 32'h104);
      chk("single.instr_d", bus.instr_d, 32'h00500093);
      chk("single.tid_d", 32'(bus.tid_d), 32'd3);
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      cyc();
      chk_state("drain1", 1'b0, 1'b1, 2'd0);
      chk("drain1.instr_nop", bus.instr_d, 32'h00000013);
      chk("drain1.pc_hold", bus.pc_d, 32'h100);

      // fill to FULL, then drain in order
      bus.ready_d = 1'b0;
      drv(1'b1, 32'h200, 32'hA, 3'd1);
      cyc();
      chk_state("fillA", 1'b1, 1'b1, 2'd1);
      drv(1'b1, 32'h204, 32'hB, 3'd1);
      cyc();
      chk_state("fillB", 1'b1, 1'b0, 2'd2);
      chk("fillB.pc_d", bus.pc_d, 32'h200);
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      bus.ready_d = 1'b1;
      cyc();
      chk_state("popA", 1'b1, 1'b1, 2'd1);
      chk("popA.pc_d", bus.pc_d, 32'h204);
      chk("popA.instr_d", bus.instr_d, 32'hB);
      cyc();
      chk_state("popB", 1'b0, 1'b1, 2'd0);

      // streaming, round-robin threads
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 32'h1000 + 32'(4 * i), 32'h7000 + 32'(i), 3'(i % 8));
         cyc();
         chk($sformatf("stream%0d.pc_d", i), bus.pc_d, 32'h1000 + 32'(4 * i));
         chk($sformatf("stream%0d.tid_d", i), 32'(bus.tid_d), 32'(i % 8));
         chk($sformatf("stream%0d.ready_f", i), 32'(bus.ready_f), 32'd1);
      end
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      cyc();
      chk_state("stream_end", 1'b0, 1'b1, 2'd0);

      // per-thread flush kills main, skid promoted
      bus.ready_d = 1'b0;
      drv(1'b1, 32'h300, 32'h31, 3'd2);
      cyc();
      drv(1'b1, 32'h304, 32'h32, 3'd5);
      cyc();
      chk_state("tidfill", 1'b1, 1'b0, 2'd2);
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      bus.flush_tid_en = 1'b1;
      bus.flush_tid    = 3'd2;
      cyc();
      chk_state("tidkill", 1'b1, 1'b1, 2'd1);
      chk("tidkill.tid_d", 32'(bus.tid_d), 32'd5);
      chk("tidkill.pc_d", bus.pc_d, 32'h304);

      // main (tid 5) killed while a tid-2 beat is pushed: new beat lands in main
      bus.flush_tid = 3'd5;
      drv(1'b1, 32'h400, 32'h41, 3'd2);
      cyc();
      chk_state("killpush", 1'b1, 1'b1, 2'd1);
      chk("killpush.pc_d", bus.pc_d, 32'h400);
      // incoming beat of the flushed thread is dropped; main (tid 2) survives
      drv(1'b1, 32'h500, 32'h51, 3'd5);
      cyc();
      chk_state("dropin", 1'b1, 1'b1, 2'd1);
      chk("dropin.pc_d", bus.pc_d, 32'h400);
      bus.flush_tid_en = 1'b0;
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      bus.ready_d = 1'b1;
      cyc();
      chk_state("tid_end", 1'b0, 1'b1, 2'd0);

      // global flush while FULL with a beat offered
      bus.ready_d = 1'b0;
      drv(1'b1, 32'h600, 32'h61, 3'd0);
      cyc();
      drv(1'b1, 32'h604, 32'h62, 3'd1);
      cyc();
      chk_state("gfill", 1'b1, 1'b0, 2'd2);
      bus.flush = 1'b1;
      drv(1'b1, 32'h608, 32'h63, 3'd2);
      cyc();
      chk_state("gflush", 1'b0, 1'b1, 2'd0);
      chk("gflush.instr_d", bus.instr_d, 32'h00000013);
      bus.flush = 1'b0;
      drv(1'b0, 32'h0, 32'h0, 3'd0);

      // asynchronous reset while FULL
      drv(1'b1, 32'h700, 32'h71, 3'd3);
      cyc();
      drv(1'b1, 32'h704, 32'h72, 3'd4);
      cyc();
      chk_state("afill", 1'b1, 1'b0, 2'd2);
      drv(1'b0, 32'h0, 32'h0, 3'd0);
      #1;
      rst = 1'b1;
      #1;
      chk_state("arst", 1'b0, 1'b1, 2'd0);
      chk("arst.instr_d", bus.instr_d, 32'h00000013);
      chk("arst.pc_d", bus.pc_d, 32'h0);
      #1;
      rst = 1'b0;
      cyc();
      chk_state("post_rst", 1'b0, 1'b1, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pl_skid_fd.md
Name: pl_skid_fd

Overview:
- Parametrised fetch→decode pipeline register for the barrel core.
- Adds a valid/ready handshake and a 2-entry skid buffer, so fetch is not combinationally coupled to decode stall.
- Supports a global flush and a per-thread flush that kills only the instructions of one redirected thread.
- Sits between the fetch stage (PC/imem, thread scheduler) and decode/regfile read.

Parameters:
- ADDRESS_WIDTH, 32, width of pc and pc_plus4.
- DATA_WIDTH, 32, instruction width.
- NUM_THREADS, 8, hardware thread count. Derived localparam BITS_THREADS = max(1, $clog2(NUM_THREADS)).
- NOP_INSTR, 32'h00000013, value driven on instr_d whenever valid_d=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  global flush; kills all held entries and the incoming beat.
- flush_tid_en  in  1  per-thread flush enable.
- flush_tid  in  BITS_THREADS  thread to kill when flush_tid_en=1.
- valid_f  in  1  fetch beat valid.
- ready_f  out  1  buffer can accept a beat. Registered; equals !skid_valid.
- pc_f, pc_plus4_f  in  ADDRESS_WIDTH  fetch PC and PC+4.
- instr_f  in  DATA_WIDTH  fetched instruction.
- tid_f  in  BITS_THREADS  fetch thread id.
- valid_d  out  1  decode beat valid (main entry valid).
- ready_d  in  1  decode accepts the beat.
- pc_d, pc_plus4_d  out  ADDRESS_WIDTH  main entry PC and PC+4.
- instr_d  out  DATA_WIDTH  main entry instruction; NOP_INSTR when valid_d=0.
- tid_d  out  BITS_THREADS  main entry thread id.
- occupancy  out  2  number of valid entries (0..2).

Behaviour:
- Storage: main entry (drives the _d outputs) and skid entry. Each entry holds pc, pc_plus4, instr, tid and a valid bit.
- Handshake terms:
  - push = valid_f & ready_f & !flush & !(flush_tid_en & tid_f==flush_tid).
  - pop = valid_d & ready_d.
- Reset (async, on rst=1):
  - All valid bits cleared; pc/pc_plus4/tid fields cleared to 0; instr fields set to NOP_INSTR.
  - Outputs after reset: valid_d=0, ready_f=1, occupancy=0, instr_d=NOP_INSTR, pc_d=pc_plus4_d=tid_d=0.
  - Reset asserted mid-operation discards all entries immediately; there is no partial state.
- Latency: 1 cycle, fetch accept to valid_d. No combinational path from fetch inputs or ready_d to any output.
- State = occupancy, one of EMPTY(0), ONE(1), FULL(2). Transitions are evaluated after the kill rules below.
  - EMPTY: push → ONE, beat loaded into main. ready_d is ignored; there is no bypass.
  - ONE, push & pop → ONE, new beat replaces main.
  - ONE, push & !pop → FULL, new beat written to skid.
  - ONE, !push & pop → EMPTY.
  - FULL: ready_f=0, so push is impossible. pop → ONE, skid moves to main, skid cleared, and ready_f rises on the next cycle.
- Order is strictly preserved: the skid entry is always younger than the main entry.
- Global flush (priority over everything except rst): next cycle all valid bits are 0 and the incoming beat is dropped. A pop in the same cycle is still counted as consumed by decode.
- Per-thread flush, evaluated in the same cycle:
  - Any held entry with tid==flush_tid is invalidated.
  - An incoming beat with tid_f==flush_tid is dropped.
  - If main is killed and skid survives, skid is promoted to main in that cycle.
  - If main is killed and push also occurs, the new beat goes to main when skid is empty or killed, otherwise to skid.
- Flushing an entry that is simultaneously popped: the pop still completes. The kill only affects the state for the next cycle.
- Invalid payload: instr_d is muxed to NOP_INSTR when valid_d=0. pc_d, pc_plus4_d and tid_d hold their last values.
- occupancy = main_valid + skid_valid; it never exceeds 2. An assertion must fire if skid_valid=1 while main_valid=0.

Test Plan:
- Reset release, then valid_f=1 pc_f=0x100 instr_f=0x00500093 tid_f=3 with ready_d=1 → next cycle valid_d=1, pc_d=0x100, pc_plus4_d=0x104, instr_d=0x00500093, tid_d=3, occupancy=1.
- ready_d=0, push beats A (pc 0x200) and B (pc 0x204) → occupancy=2, ready_f=0 the cycle after B. Raise ready_d → A then B appear on consecutive cycles, and ready_f=1 one cycle after A pops.
- Streaming with ready_d=1 and valid_f=1 for 16 cycles, round-robin tid 0..7 → one beat per cycle out, in order, ready_f never drops.
- FULL with main tid=2 and skid tid=5, flush_tid_en=1, flush_tid=2 → next cycle valid_d=1, tid_d=5, occupancy=1.
- FULL state with flush=1 and valid_f=1 in the same cycle → next cycle valid_d=0, instr_d=0x00000013, occupancy=0, ready_f=1.
- rst asserted asynchronously mid-cycle while FULL → valid_d=0 and ready_f=1 immediately, with no clock edge required.
